// File: rtl/mc_main_fsm_if.sv
// mc_main_fsm_if: control bundle between the main FSM (master) and the multi-cycle datapath (slave)
// Carries illegal_op only when ILLEGAL_OP_TRAP_EN is defined.
interface mc_main_fsm_if #(parameter int STALL_W = 8);
    logic [6:0]         op;
    logic               zero;
    logic               mem_ready;
    logic               pc_write;
    logic               ir_write;
    logic               reg_write;
    logic               mem_write;
    logic               adr_src;
    logic [1:0]         result_src;
    logic [1:0]         alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         alu_op;
    logic               instr_retired;
    logic [STALL_W-1:0] stall_cnt;
`ifdef ILLEGAL_OP_TRAP_EN
    logic               illegal_op;
    modport master (input op, zero, mem_ready,
                    output pc_write, ir_write, reg_write, mem_write, adr_src, result_src,
                           alu_src_a, alu_src_b, alu_op, instr_retired, stall_cnt, illegal_op);
    modport slave  (output op, zero, mem_ready,
                    input  pc_write, ir_write, reg_write, mem_write, adr_src, result_src,
                           alu_src_a, alu_src_b, alu_op, instr_retired, stall_cnt, illegal_op);
`else
    modport master (input op, zero, mem_ready,
                    output pc_write, ir_write, reg_write, mem_write, adr_src, result_src,
                           alu_src_a, alu_src_b, alu_op, instr_retired, stall_cnt);
    modport slave  (output op, zero, mem_ready,
                    input  pc_write, ir_write, reg_write, mem_write, adr_src, result_src,
                           alu_src_a, alu_src_b, alu_op, instr_retired, stall_cnt);
`endif
endinterface

// File: rtl/mc_main_fsm.sv
// mc_main_fsm: main control FSM of the multi-cycle RV32 core; define ILLEGAL_OP_TRAP_EN to trap unknown opcodes
module mc_main_fsm #(
    parameter logic [6:0] JALR_OP = 7'b1000011,
    parameter logic [6:0] LUI_OP  = 7'b0110111,
    parameter int         STALL_W = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    mc_main_fsm_if.master bus
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI,
        LUI, ALUWB, BEQ, JAL, JALR, JALRLINK, TRAP
    } state_t;

    state_t             state_q, state_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               stalling;

    assign stalling  = (state_q == FETCH || state_q == MEMREAD || state_q == MEMWRITE) && !bus.mem_ready;
    assign stall_d   = (stalling && !(&stall_q)) ? stall_q + 1'b1 : stall_q;
    assign bus.stall_cnt = stall_q;
`ifdef ILLEGAL_OP_TRAP_EN
    assign bus.illegal_op = reset_n && state_q == TRAP;
`endif

    // state and stall-counter registers; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
        end
    end

    // next state and Moore outputs; everything is forced low while reset is held
    always_comb begin
        state_d           = state_q;
        bus.pc_write      = 1'b0;
        bus.ir_write      = 1'b0;
        bus.reg_write     = 1'b0;
        bus.mem_write     = 1'b0;
        bus.adr_src       = 1'b0;
        bus.result_src    = 2'b00;
        bus.alu_src_a     = 2'b00;
        bus.alu_src_b     = 2'b00;
        bus.alu_op        = 2'b00;
        bus.instr_retired = 1'b0;
        case (state_q)
            FETCH: begin
                bus.alu_src_b  = 2'b10;
                bus.result_src = 2'b10;
                bus.pc_write   = bus.mem_ready;
                bus.ir_write   = bus.mem_ready;
                state_d        = bus.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b01;
                case (bus.op)
                    7'b0000011, 7'b0100011: state_d = MEMADR;
                    7'b0110011:             state_d = EXECUTER;
                    7'b0010011:             state_d = EXECUTEI;
                    7'b1100011:             state_d = BEQ;
                    7'b1101111:             state_d = JAL;
                    JALR_OP:                state_d = JALR;
                    LUI_OP:                 state_d = LUI;
`ifdef ILLEGAL_OP_TRAP_EN
                    default:                state_d = TRAP;
`else
                    default: begin
                        state_d           = FETCH;
                        bus.instr_retired = 1'b1;
                    end
`endif
                endcase
            end
            MEMADR: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
                state_d       = (bus.op == 7'b0000011) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                bus.adr_src = 1'b1;
                state_d     = bus.mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                bus.result_src    = 2'b01;
                bus.reg_write     = 1'b1;
                bus.instr_retired = 1'b1;
                state_d           = FETCH;
            end
            MEMWRITE: begin
                bus.adr_src       = 1'b1;
                bus.mem_write     = 1'b1;
                bus.instr_retired = bus.mem_ready;
                state_d           = bus.mem_ready ? FETCH : MEMWRITE;
            end
            EXECUTER: begin
                bus.alu_src_a = 2'b10;
                bus.alu_op    = 2'b10;
                state_d       = ALUWB;
            end
            EXECUTEI: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
                bus.alu_op    = 2'b10;
                state_d       = ALUWB;
            end
            LUI: begin
                bus.alu_src_a = 2'b11;
                bus.alu_src_b = 2'b01;
                state_d       = ALUWB;
            end
            ALUWB: begin
                bus.reg_write     = 1'b1;
                bus.instr_retired = 1'b1;
                state_d           = FETCH;
            end
            BEQ: begin
                bus.alu_src_a     = 2'b10;
                bus.alu_op        = 2'b01;
                bus.pc_write      = bus.zero;
                bus.instr_retired = 1'b1;
                state_d           = FETCH;
            end
            JAL: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b10;
                bus.pc_write  = 1'b1;
                state_d       = ALUWB;
            end
            JALR: begin
                bus.alu_src_a  = 2'b10;
                bus.alu_src_b  = 2'b01;
                bus.result_src = 2'b10;
                bus.pc_write   = 1'b1;
                state_d        = JALRLINK;
            end
            JALRLINK: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b10;
                state_d       = ALUWB;
            end
            default: state_d = state_q;
        endcase
        if (!reset_n) begin
            bus.pc_write      = 1'b0;
            bus.ir_write      = 1'b0;
            bus.reg_write     = 1'b0;
            bus.mem_write     = 1'b0;
            bus.adr_src       = 1'b0;
            bus.result_src    = 2'b00;
            bus.alu_src_a     = 2'b00;
            bus.alu_src_b     = 2'b00;
            bus.alu_op        = 2'b00;
            bus.instr_retired = 1'b0;
        end
    end
endmodule

// File: tb/tb_mc_main_fsm.sv
// tb_mc_main_fsm: random instruction stream against a per-instruction cycle/strobe model of mc_main_fsm
module tb_mc_main_fsm;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1000011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_BAD  = 7'b1111111;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_stall = 0;

    mc_main_fsm_if #(.STALL_W(8)) bus();
    mc_main_fsm dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int base_cycles(input logic [6:0] op);
        case (op)
            OP_LW, OP_JALR:               return 5;
            OP_SW, OP_R, OP_I, OP_LUI, OP_JAL: return 4;
            OP_BEQ:                       return 3;
            default:                      return 2;
        endcase
    endfunction

    function automatic bit writes_rd(input logic [6:0] op);
        return op == OP_LW || op == OP_R || op == OP_I || op == OP_LUI || op == OP_JAL || op == OP_JALR;
    endfunction

    // Runs one instruction starting in FETCH: fs stall cycles before fetch completes,
    // ms stall cycles at the start of the memory access (lw/sw only).
    task automatic run_instr(input logic [6:0] op, input int fs, input int ms, input logic z);
        bit is_mem  = (op == OP_LW || op == OP_SW);
        int exp_cyc = base_cycles(op) + fs + (is_mem ? ms : 0);
        int exp_pw  = 1 + ((op == OP_BEQ && z) ? 1 : 0) + ((op == OP_JAL || op == OP_JALR) ? 1 : 0);
        int cyc = 0, rw = 0, mw = 0, pw = 0, iw = 0, ret_at = -1, rw_at = -1, rs_last = -1;
        bus.op   = op;
        bus.zero = z;
        while (ret_at < 0 && cyc < exp_cyc + 20) begin
            bus.mem_ready = !(cyc < fs || (is_mem && cyc >= fs + 3 && cyc < fs + 3 + ms));
            @(negedge clk);
            if (cyc == 0) chk("fetch_alu_src_b", bus.alu_src_b, 2);
            rw += bus.reg_write;
            mw += bus.mem_write;
            pw += bus.pc_write;
            iw += bus.ir_write;
            if (bus.reg_write) rw_at = cyc;
            if (bus.instr_retired) begin
                ret_at  = cyc;
                rs_last = bus.result_src;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        exp_stall = exp_stall + fs + (is_mem ? ms : 0);
        if (exp_stall > 255) exp_stall = 255;
        chk($sformatf("cycles op=%b", op), ret_at + 1, exp_cyc);
        chk("reg_write_count", rw, writes_rd(op) ? 1 : 0);
        chk("reg_write_cycle", rw_at, writes_rd(op) ? exp_cyc - 1 : -1);
        chk("mem_write_count", mw, (op == OP_SW) ? ms + 1 : 0);
        chk("pc_write_count", pw, exp_pw);
        chk("ir_write_count", iw, 1);
        chk("retire_result_src", rs_last, (op == OP_LW) ? 1 : 0);
        chk("stall_cnt", bus.stall_cnt, exp_stall);
    endtask

    initial begin
        logic [6:0] ops [10] = '{OP_LW, OP_SW, OP_R, OP_I, OP_LUI, OP_BEQ, OP_JAL, OP_JALR, OP_BAD, 7'b0000000};
        bus.op = OP_R;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b1;
        #12;
        chk("rst_alu_src_b", bus.alu_src_b, 0);
        chk("rst_result_src", bus.result_src, 0);
        chk("rst_pc_write", bus.pc_write, 0);
        chk("rst_ir_write", bus.ir_write, 0);
        chk("rst_stall_cnt", bus.stall_cnt, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        run_instr(OP_R, 0, 0, 1'b0);
        run_instr(OP_LW, 0, 3, 1'b0);
        run_instr(OP_BEQ, 0, 0, 1'b1);
        run_instr(OP_BEQ, 0, 0, 1'b0);
        run_instr(OP_JALR, 0, 0, 1'b0);
        run_instr(OP_SW, 0, 2, 1'b0);
`ifndef ILLEGAL_OP_TRAP_EN
        run_instr(OP_BAD, 0, 0, 1'b0);
`endif

        // reset in the middle of a stalled store
        bus.op = OP_SW;
        bus.mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus.mem_ready = 1'b0;
        @(negedge clk);
        chk("sw_mem_write_before_rst", bus.mem_write, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("sw_mem_write_in_rst", bus.mem_write, 0);
        chk("sw_stall_cnt_in_rst", bus.stall_cnt, 0);
        exp_stall = 0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        run_instr(OP_R, 1, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
`ifdef ILLEGAL_OP_TRAP_EN
            run_instr(ops[$urandom_range(0, 7)], $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
`else
            run_instr(ops[$urandom_range(0, 9)], $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
`endif
        end

        run_instr(OP_I, 260, 0, 1'b0);
        chk("stall_cnt_saturated", bus.stall_cnt, 255);

`ifdef ILLEGAL_OP_TRAP_EN
        run_instr(OP_R, 0, 0, 1'b0);
        bus.op = OP_BAD;
        bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("trap_illegal_op", bus.illegal_op, 1);
            chk("trap_ir_write", bus.ir_write, 0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mc_main_fsm.md
Name: mc_main_fsm

Overview:
- Main control state machine for the multi-cycle RV32 core.
- Sequences the shared datapath (single memory port, single ALU, IR/OldPC/ALUOut/Data registers) through fetch, decode, execute, memory and writeback steps.
- Sits beside the immediate-source decoder and ALU decoder. Consumes the opcode, the ALU zero flag and a memory-ready handshake; drives every datapath enable and mux select.

Parameters:
JALR_OP, 7'b1000011, opcode treated as jalr (team encoding)
LUI_OP, 7'b0110111, opcode treated as lui
STALL_W, 8, width of the memory-stall counter

Ports:
clk  in  1  core clock, rising edge
reset_n  in  1  asynchronous active-low reset
op  in  7  opcode field of IR
zero  in  1  ALU zero flag, for beq
mem_ready  in  1  memory completes current access this cycle
pc_write  out  1  PC load enable (PCUpdate | (Branch & zero))
ir_write  out  1  IR and OldPC load enable
reg_write  out  1  register-file write enable
mem_write  out  1  memory write strobe
adr_src  out  1  0 = PC, 1 = ALUOut as memory address
result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult
alu_src_a  out  2  00 PC, 01 OldPC, 10 RD1, 11 constant zero
alu_src_b  out  2  00 WriteData, 01 ImmExt, 10 constant 4
alu_op  out  2  00 add, 01 sub (beq), 10 funct-decoded
instr_retired  out  1  one-cycle pulse when an instruction completes
stall_cnt  out  STALL_W  saturating count of mem_ready-low cycles in FETCH/MEMREAD/MEMWRITE

Behaviour:
- Moore FSM; outputs depend on state only, except pc_write/ir_write/mem_write gating by mem_ready or zero as noted.
- Async reset: state = FETCH, stall_cnt = 0. All outputs are 0 while reset_n is low, including alu_src_b.
- FETCH:
  - adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_write and pc_write are asserted only when mem_ready=1; the FSM then goes to DECODE. Otherwise it stays in FETCH.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch/jal target into ALUOut). Next state by op:
  - 0000011/0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - JALR_OP -> JALR
  - LUI_OP -> LUI
  - any other opcode -> see Optional Feature
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. lw -> MEMREAD; sw -> MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Waits for mem_ready=1, then -> MEMWB.
- MEMWB: result_src=01, reg_write=1, retire -> FETCH.
- MEMWRITE: adr_src=1, result_src=00. mem_write is asserted every cycle in this state. Exits when mem_ready=1, then retire -> FETCH.
- EXECUTER: alu_src_a=10, alu_src_b=00, alu_op=10 -> ALUWB.
- EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10 -> ALUWB.
- LUI: alu_src_a=11, alu_src_b=01, alu_op=00 -> ALUWB.
- ALUWB: result_src=00, reg_write=1, retire -> FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00. pc_write=zero; retire -> FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1 -> ALUWB (rd = OldPC+4).
- JALR: alu_src_a=10, alu_src_b=01, alu_op=00, result_src=10, pc_write=1 -> JALRLINK.
- JALRLINK: alu_src_a=01, alu_src_b=10, alu_op=00 -> ALUWB.
- Retire: instr_retired pulses in the cycle the FSM leaves a terminal state (MEMWB, MEMWRITE exit, ALUWB, BEQ).
- Cycle counts with mem_ready held at 1:
  - lw 5
  - sw 4
  - R/I/lui 4
  - beq 3
  - jal 4
  - jalr 5
- stall_cnt increments in FETCH/MEMREAD/MEMWRITE when mem_ready=0. It saturates at all-ones and never wraps.
- Reset asserted mid-instruction aborts immediately. No partial write is completed after reset deassertion.

Optional Feature:
- ILLEGAL_OP_TRAP_EN defined:
  - An unknown opcode in DECODE -> TRAP state.
  - TRAP: all enables 0, adds output illegal_op=1 (sticky).
  - The FSM stays in TRAP until reset.
- ILLEGAL_OP_TRAP_EN undefined:
  - An unknown opcode is treated as a nop: DECODE -> FETCH with instr_retired pulsed.
  - No illegal_op port exists.

Test Plan:
- add (op=0110011), mem_ready=1 -> FETCH, DECODE, EXECUTER, ALUWB; reg_write=1 only in cycle 4; instr_retired pulses once.
- lw (op=0000011), mem_ready low 3 cycles in MEMREAD -> 8 cycles total; stall_cnt=3; reg_write with result_src=01 in the final cycle.
- beq with zero=1, then with zero=0 -> pc_write=1 in the BEQ cycle only for the taken case; 3 cycles each.
- jalr (op=1000011) -> DECODE, JALR (pc_write=1, result_src=10), JALRLINK, ALUWB (reg_write=1).
- sw with mem_ready=0 for 2 cycles -> mem_write held for 3 cycles; reset_n pulled low during MEMWRITE -> mem_write drops asynchronously and the FSM restarts in FETCH.
- op=1111111 -> with ILLEGAL_OP_TRAP_EN: illegal_op=1 held and no further ir_write; without it: back to FETCH after 2 cycles.
